// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared sizing and types for the single-clock FIFO slice.
//   DATA_W : data word width in bits
//   DEPTH  : number of storage entries (power of two)
//   ADDR_W : storage address width, $clog2(DEPTH)
//   ptr_t  : read/write pointer, one extra MSB used as the wrap bit
//   data_t : one stored word
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef logic [ADDR_W:0]   ptr_t;
    typedef logic [DATA_W-1:0] data_t;

    // Pointers are equal in the low bits and differ in the wrap bit -> full.
    function automatic logic ptr_full(input ptr_t wp, input ptr_t rp);
        return (wp[ADDR_W] != rp[ADDR_W]) && (wp[ADDR_W-1:0] == rp[ADDR_W-1:0]);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
//   DEPTH x DATA_W storage with one synchronous write port and one
//   synchronous read port. The array itself carries no reset; only the
//   read-data register is reset so the FIFO output comes up at zero.
//
//   w_clk    in   clock
//   w_rst    in   async active-high reset (read-data register only)
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe, loads rd_data at the edge
//   rd_addr  in   read address
//   rd_data  out  registered read data, holds when rd_en=0
// -----------------------------------------------------------------------------
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = fifo_pkg::DATA_W,
    parameter int DEPTH  = fifo_pkg::DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge w_clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // The controller never reads and writes the same slot in one cycle
    // (read needs !empty, write needs !full), so no bypass is required.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fifo_16_8.sv
// -----------------------------------------------------------------------------
// fifo_16_8
//   Single-clock FIFO, DEPTH entries of DATA_W bits, one-cycle registered
//   read. Pointers are ADDR_W+1 bits; the MSB is a wrap bit so that the
//   equal-pointer case can be told apart as empty (wrap equal) or full
//   (wrap differs).
//
//   w_clk  in   clock, all state on rising edge
//   w_rst  in   async active-high reset
//   w_en   in   write request
//   d_in   in   write data
//   r_en   in   read request
//   d_out  out  registered read data, holds when no read is accepted
//   full   out  DEPTH entries stored
//   empty  out  zero entries stored
// -----------------------------------------------------------------------------
module fifo_16_8
    import fifo_pkg::*;
#(
    parameter int DATA_W = fifo_pkg::DATA_W,
    parameter int DEPTH  = fifo_pkg::DEPTH
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_en,
    input  logic [DATA_W-1:0] d_in,
    input  logic              r_en,
    output logic [DATA_W-1:0] d_out,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        wr_acc;
    logic        rd_acc;

    // Flags come straight from the registered pointers, so they track
    // reset asynchronously and reflect an operation the cycle after it.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Each side is gated only by its own pre-edge flag; both may fire.
    assign wr_acc = w_en && !full;
    assign rd_acc = r_en && !empty;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .w_clk   (w_clk),
        .w_rst   (w_rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (d_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (d_out)
    );

endmodule

// File: tb/tb_fifo_16_8.sv
// -----------------------------------------------------------------------------
// tb_fifo_16_8
//   Directed bench for fifo_16_8. Inputs change 1ns after a rising edge;
//   outputs are checked 1ns after the following rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_16_8;

    logic       w_clk;
    logic       w_rst;
    logic       w_en;
    logic [7:0] d_in;
    logic       r_en;
    logic [7:0] d_out;
    logic       full;
    logic       empty;

    int n_test;
    int n_fail;

    fifo_16_8 dut (
        .w_clk (w_clk),
        .w_rst (w_rst),
        .w_en  (w_en),
        .d_in  (d_in),
        .r_en  (r_en),
        .d_out (d_out),
        .full  (full),
        .empty (empty)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_test++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and land 1ns past it.
    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic idle();
        w_en = 1'b0;
        r_en = 1'b0;
    endtask

    initial begin
        n_test = 0;
        n_fail = 0;
        w_rst  = 1'b1;
        w_en   = 1'b0;
        r_en   = 1'b0;
        d_in   = 8'h00;

        // Reset state, before any clock edge
        #3;
        chk("rst_empty", empty, 1);
        chk("rst_full",  full,  0);
        chk("rst_dout",  d_out, 8'h00);
        step();
        w_rst = 1'b0;

        // Read while empty after reset
        r_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_rd_dout",  d_out, 8'h00);
            chk("rst_rd_empty", empty, 1);
        end
        idle();

        // Fill 01..10
        for (int i = 1; i <= 16; i++) begin
            w_en = 1'b1;
            d_in = 8'(i);
            step();
            chk("fill_full",  full,  (i == 16) ? 1 : 0);
            chk("fill_empty", empty, 0);
        end

        // Overflow writes are dropped
        d_in = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ovf_full", full, 1);
        end
        idle();

        // Drain: 01..10 in order, never AA
        r_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("drain_dout",  d_out, i);
            chk("drain_empty", empty, (i == 16) ? 1 : 0);
            chk("drain_full",  full,  0);
        end

        // Underflow: d_out holds 10
        for (int i = 0; i < 5; i++) begin
            step();
            chk("udf_dout",  d_out, 8'h10);
            chk("udf_empty", empty, 1);
        end
        idle();

        // Wrap: write 10, read 10, write 16
        w_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d_in = 8'h20 + 8'(i);
            step();
        end
        idle();
        r_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("wrap_rd10", d_out, 8'h20 + i);
        end
        chk("wrap_rd10_empty", empty, 1);
        idle();
        w_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d_in = 8'h40 + 8'(i);
            step();
        end
        chk("wrap_full", full, 1);

        // Both while full: only the read happens
        r_en = 1'b1;
        d_in = 8'h99;
        step();
        chk("both_full_dout", d_out, 8'h40);
        chk("both_full_full", full,  0);
        idle();
        r_en = 1'b1;
        for (int i = 1; i < 16; i++) begin
            step();
            chk("wrap_drain", d_out, 8'h40 + i);
        end
        chk("wrap_drain_empty", empty, 1);
        idle();

        // Both while empty: only the write, no bypass
        w_en = 1'b1;
        r_en = 1'b1;
        d_in = 8'h5A;
        step();
        chk("both_empty_dout",  d_out, 8'h4F);
        chk("both_empty_empty", empty, 0);
        w_en = 1'b0;
        step();
        chk("both_empty_rd", d_out, 8'h5A);
        chk("both_empty_e2", empty, 1);
        idle();

        // Concurrent with 5 stored
        w_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d_in = 8'h60 + 8'(i);
            step();
        end
        r_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d_in = 8'h70 + 8'(i);
            step();
            chk("conc_dout",  d_out, 8'h60 + i);
            chk("conc_full",  full,  0);
            chk("conc_empty", empty, 0);
        end
        w_en = 1'b0;
        step();
        chk("conc_tail0", d_out, 8'h64);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("conc_tail", d_out, 8'h70 + i);
        end
        chk("conc_end_empty", empty, 1);
        idle();

        // Async reset mid-stream with 7 stored
        w_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d_in = 8'h80 + 8'(i);
            step();
        end
        w_en = 1'b0;
        r_en = 1'b1;
        step();
        chk("pre_rst_dout", d_out, 8'h80);
        idle();
        #2;
        w_rst = 1'b1;
        #1;
        chk("arst_empty", empty, 1);
        chk("arst_full",  full,  0);
        chk("arst_dout",  d_out, 8'h00);
        step();
        w_rst = 1'b0;
        w_en  = 1'b1;
        d_in  = 8'h55;
        step();
        chk("post_rst_empty", empty, 0);
        w_en = 1'b0;
        r_en = 1'b1;
        step();
        chk("post_rst_dout",  d_out, 8'h55);
        chk("post_rst_empty2", empty, 1);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_16_8.md
FIFO_16_8 -- requirements
Module: fifo_16_8

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 16, number of storage entries (power of two).
REQ-003 Single clock: the block SHALL have one clock (w_clk) and an asynchronous, active-high reset (w_rst); polarity and synchronicity are fixed.
REQ-004 w_clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 w_rst  input  1  asynchronous active-high reset.
REQ-006 w_en  input  1  write request, sampled at rising w_clk.
REQ-007 d_in  input  DATA_W  write data, captured when a write is accepted.
REQ-008 r_en  input  1  read request, sampled at rising w_clk.
REQ-009 d_out  output  DATA_W  registered read data.
REQ-010 full  output  1  high when DEPTH entries are stored.
REQ-011 empty  output  1  high when zero entries are stored.

Function
REQ-012 A write SHALL be accepted at a rising edge when w_en=1 and full=0; d_in is stored at the write-pointer location, and the write pointer increments.
REQ-013 A write request with full=1 SHALL be ignored: no storage change, no pointer change, and no corruption of stored data.
REQ-014 A read SHALL be accepted at a rising edge when r_en=1 and empty=0; the entry at the read pointer is loaded into d_out at that edge, and the read pointer increments.
REQ-015 Read latency SHALL be one cycle: d_out reflects the popped word immediately after the accepting edge.
REQ-016 d_out SHALL hold its last value whenever no read is accepted, including r_en=1 while empty.
REQ-017 Data SHALL be returned in strict first-in, first-out order.
REQ-018 Pointers SHALL be log2(DEPTH)+1 bits wide (5 bits by default); the MSB is a wrap bit, and the low bits address storage, wrapping from DEPTH-1 to 0.
REQ-019 empty SHALL be 1 when the read and write pointers are equal, including the wrap bit.
REQ-020 full SHALL be 1 when the pointers differ only in the wrap bit.
REQ-021 Flags SHALL be derived from the registered pointers and reflect an accepted operation in the cycle after its edge.
REQ-022 Simultaneous w_en and r_en SHALL be accepted as independent operations, each gated by the flag value before the edge:
  - Both accepted: occupancy is unchanged.
  - While full: only the read is performed.
  - While empty: only the write is performed; the word is not bypassed to d_out.
REQ-023 The block SHALL NOT contain any cross-clock synchronisers, because there is one clock domain.

Reset
REQ-024 While w_rst=1, both pointers SHALL be 0, with empty=1, full=0 and d_out=0, independent of w_clk.
REQ-025 Reset asserted mid-operation SHALL discard all stored contents logically; storage array contents need not be cleared.
REQ-026 After reset deassertion, the first rising edge SHALL accept operations normally.

Structure
REQ-027 A shared package fifo_pkg SHALL hold DATA_W, DEPTH and ADDR_W = $clog2(DEPTH), plus the pointer typedef (ADDR_W+1 bits) and the data typedef (DATA_W bits).
REQ-028 Storage SHALL be a sub-module fifo_mem: DEPTH x DATA_W, one synchronous write port and one synchronous read port, with no reset on the array.
REQ-029 Pointer and flag logic SHALL reside in fifo_16_8.

Verification
REQ-030 Reset check: after reset, empty=1, full=0, d_out=8'h00; r_en=1 for 3 cycles -> d_out stays 8'h00 and empty stays 1.
REQ-031 Fill and drain: write 8'h01..8'h10 (16 words) -> full=1 after the 16th edge; then read 16 -> d_out = 8'h01..8'h10 in order, and empty=1 after the last read.
REQ-032 Overflow: with the FIFO full, write 8'hAA for 4 cycles -> full stays 1 and stored data is unchanged; the subsequent drain returns the original 16 words with no 8'hAA.
REQ-033 Underflow: with the FIFO empty, assert r_en for 5 cycles -> d_out stable at the last value, and empty stays 1.
REQ-034 Wrap and concurrency:
  - Write 10 words, then read 10 words, then write 16 words -> pointers wrap, full=1, and data order is preserved.
  - Concurrent w_en=r_en=1 with 5 entries stored -> occupancy stays 5 and full/empty stay 0.
REQ-035 Async reset: assert w_rst mid-stream with 7 entries stored, between clock edges -> empty=1, full=0 and d_out=0 immediately; a write of 8'h55 then a read returns 8'h55.
